// File: rtl/sram_cache_pkg.sv
// Shared constants for the SRAM read cache: FSM encodings, SRAM base and default geometry.
package sram_cache_pkg;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LINES      = 256;
    localparam logic [7:0] SRAM_BASE = 8'h80;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOOKUP = 2'd1;
    localparam state_t ST_FILL   = 2'd2;
    localparam state_t ST_WRITE  = 2'd3;

endpackage

// File: rtl/sram_cache_ram.sv
// Single-port synchronous-read RAM with four byte-lane write enables.
module sram_cache_ram #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] w_mask;

    // Lane k covers bits [8k+7:8k]; narrower words simply use the low lanes.
    for (genvar b = 0; b < WIDTH; b++) begin : g_mask
        assign w_mask[b] = i_we[b / 8];
    end

    always_ff @(posedge i_clk) begin
        if (|i_we) begin
            r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_cache.sv
// Direct-mapped write-through, no-write-allocate read cache in front of the SRAM controller.
// Define CACHE_STATS_EN to build the read hit/miss counters.
module sram_cache
    import sram_cache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LINES      = DEF_LINES,
    parameter int AW         = 21
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_stb,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_dat_w,
    output logic [31:0]   o_dat_r,
    output logic          o_ack,
    input  logic          i_flush,
    output logic          o_busy,
    output logic          o_mem_stb,
    output logic [3:0]    o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_dat_w,
    input  logic [31:0]   i_mem_dat_r,
    input  logic          i_mem_ack,
    output logic [31:0]   o_hits,
    output logic [31:0]   o_misses
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = AW - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    state_t              r_state;
    logic                r_flush_pend;
    logic [LINES-1:0]    r_valid;
    logic [AW-1:0]       r_addr;
    logic [3:0]          r_we;
    logic [31:0]         r_dat_w;
    logic [OFF_W-1:0]    r_cnt;
    logic                r_hit;
    logic [31:0]         r_word;
    logic                r_ack;
    logic [31:0]         r_dat_r;
    logic                r_mem_stb;
    logic [3:0]          r_mem_we;
    logic [AW-1:0]       r_mem_addr;
    logic [31:0]         r_mem_dat_w;

    logic [IDX_W-1:0]       w_idx;
    logic [OFF_W-1:0]       w_off;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic                   w_fill_last;
    logic [IDX_W+OFF_W-1:0] w_data_addr;
    logic [3:0]             w_data_we;
    logic [31:0]            w_data_wdata;
    logic [31:0]            w_data_rdata;
    logic [IDX_W-1:0]       w_tag_addr;
    logic [3:0]             w_tag_we;
    logic [TAG_W-1:0]       w_tag_rdata;

    assign w_off       = r_addr[OFF_W-1:0];
    assign w_idx       = r_addr[IDX_W+OFF_W-1:OFF_W];
    assign w_tag       = r_addr[AW-1:IDX_W+OFF_W];
    assign w_hit       = r_valid[w_idx] && (w_tag_rdata == w_tag);
    assign w_fill_last = (r_state == ST_FILL) && i_mem_ack && (r_cnt == LAST_WORD);

    // In IDLE the RAMs are addressed from the live request so LOOKUP sees tag/data one edge later.
    always_comb begin
        w_data_addr  = r_addr[IDX_W+OFF_W-1:0];
        w_data_we    = 4'b0000;
        w_data_wdata = r_dat_w;
        w_tag_addr   = w_idx;
        w_tag_we     = {4{w_fill_last}};
        if (r_state == ST_IDLE) begin
            w_data_addr = i_addr[IDX_W+OFF_W-1:0];
            w_tag_addr  = i_addr[IDX_W+OFF_W-1:OFF_W];
        end else if (r_state == ST_FILL) begin
            w_data_addr  = {w_idx, r_cnt};
            w_data_wdata = i_mem_dat_r;
            if (i_mem_ack) w_data_we = 4'b1111;
        end else if (r_state == ST_WRITE) begin
            if (i_mem_ack && r_hit) w_data_we = r_we;
        end
    end

    sram_cache_ram #(
        .DEPTH (LINES * LINE_WORDS),
        .WIDTH (32)
    ) u_data_ram (
        .i_clk   (i_clk),
        .i_addr  (w_data_addr),
        .i_we    (w_data_we),
        .i_wdata (w_data_wdata),
        .o_rdata (w_data_rdata)
    );

    sram_cache_ram #(
        .DEPTH (LINES),
        .WIDTH (TAG_W)
    ) u_tag_ram (
        .i_clk   (i_clk),
        .i_addr  (w_tag_addr),
        .i_we    (w_tag_we),
        .i_wdata (w_tag),
        .o_rdata (w_tag_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_flush_pend <= 1'b0;
            r_valid      <= '0;
            r_addr       <= '0;
            r_we         <= 4'b0000;
            r_dat_w      <= '0;
            r_cnt        <= '0;
            r_hit        <= 1'b0;
            r_word       <= '0;
            r_ack        <= 1'b0;
            r_dat_r      <= '0;
            r_mem_stb    <= 1'b0;
            r_mem_we     <= 4'b0000;
            r_mem_addr   <= '0;
            r_mem_dat_w  <= '0;
        end else begin
            r_ack   <= 1'b0;
            r_dat_r <= '0;
            if (i_flush && r_state != ST_IDLE) r_flush_pend <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (i_flush || r_flush_pend) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end
                    // i_stb during the ack cycle still belongs to the request just completed.
                    if (i_stb && !r_ack) begin
                        r_state <= ST_LOOKUP;
                        r_addr  <= i_addr;
                        r_we    <= i_we;
                        r_dat_w <= i_dat_w;
                    end
                end
                ST_LOOKUP: begin
                    if (r_we == 4'b0000) begin
                        if (w_hit) begin
                            r_ack   <= 1'b1;
                            r_dat_r <= w_data_rdata;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_FILL;
                            r_cnt      <= '0;
                            r_mem_stb  <= 1'b1;
                            r_mem_we   <= 4'b0000;
                            r_mem_addr <= {r_addr[AW-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end else begin
                        r_hit       <= w_hit;
                        r_state     <= ST_WRITE;
                        r_mem_stb   <= 1'b1;
                        r_mem_we    <= r_we;
                        r_mem_addr  <= r_addr;
                        r_mem_dat_w <= r_dat_w;
                    end
                end
                ST_FILL: begin
                    if (i_mem_ack) begin
                        if (r_cnt == w_off) r_word <= i_mem_dat_r;
                        if (r_cnt == LAST_WORD) begin
                            r_mem_stb      <= 1'b0;
                            r_valid[w_idx] <= 1'b1;
                            r_ack          <= 1'b1;
                            r_dat_r        <= (r_cnt == w_off) ? i_mem_dat_r : r_word;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_mem_addr <= r_mem_addr + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (i_mem_ack) begin
                        r_mem_stb <= 1'b0;
                        r_mem_we  <= 4'b0000;
                        r_ack     <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hits;
    logic [31:0] r_misses;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else if (r_state == ST_LOOKUP && r_we == 4'b0000) begin
            if (w_hit) r_hits <= r_hits + 32'd1;
            else       r_misses <= r_misses + 32'd1;
        end
    end

    assign o_hits   = r_hits;
    assign o_misses = r_misses;
`else
    assign o_hits   = '0;
    assign o_misses = '0;
`endif

    assign o_dat_r     = r_dat_r;
    assign o_ack       = r_ack;
    assign o_busy      = (r_state != ST_IDLE) || r_flush_pend;
    assign o_mem_stb   = r_mem_stb;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_dat_w = r_mem_dat_w;

endmodule
